// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: fetch entry -> decode, with stall-cycle counter. Optional skid entry via IF_ID_SKID_EN.
// Latency: one cycle from acceptance to out_valid when the output register is free or drains the same cycle.
// Backpressure: default in_ready = out_ready || !out_valid; IF_ID_SKID_EN gives registered in_ready = !skid_valid.
module if_id_pipe #(
    parameter int INS_W = 32,
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INS_W-1:0] ins_in,
    input  logic [PC_W-1:0]  pc_cur_in,
    input  logic [PC_W-1:0]  pc_next_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INS_W-1:0] ins_out,
    output logic [PC_W-1:0]  pc_cur_out,
    output logic [PC_W-1:0]  pc_next_out,
    output logic [CNT_W-1:0] stall_cnt
);

    logic in_xfer;
    assign in_xfer = in_valid && in_ready;

`ifdef IF_ID_SKID_EN
    logic             skid_valid;
    logic [INS_W-1:0] skid_ins;
    logic [PC_W-1:0]  skid_pc_cur;
    logic [PC_W-1:0]  skid_pc_next;

    // skid_valid is a flop, so in_ready carries no path from out_ready
    assign in_ready = !skid_valid;
`else
    assign in_ready = out_ready || !out_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid   <= 1'b0;
            ins_out     <= '0;
            pc_cur_out  <= '0;
            pc_next_out <= '0;
`ifdef IF_ID_SKID_EN
            skid_valid  <= 1'b0;
`endif
        end else if (!out_valid || out_ready) begin
`ifdef IF_ID_SKID_EN
            if (skid_valid) begin
                out_valid   <= 1'b1;
                ins_out     <= skid_ins;
                pc_cur_out  <= skid_pc_cur;
                pc_next_out <= skid_pc_next;
                skid_valid  <= 1'b0;
            end else if (in_xfer) begin
`else
            if (in_xfer) begin
`endif
                out_valid   <= 1'b1;
                ins_out     <= ins_in;
                pc_cur_out  <= pc_cur_in;
                pc_next_out <= pc_next_in;
            end else begin
                out_valid   <= 1'b0;
            end
        end
`ifdef IF_ID_SKID_EN
        else if (in_xfer) begin
            // output held: park the new entry behind it
            skid_valid   <= 1'b1;
            skid_ins     <= ins_in;
            skid_pc_cur  <= pc_cur_in;
            skid_pc_next <= pc_next_in;
        end
`endif
    end

    // Counts stalled cycles regardless of flush; saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed bench for if_id_pipe: vector table plus hand sequences for stall, stream, flush and skid cases.
module tb_if_id_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ins_in;
    logic [7:0]  pc_cur_in;
    logic [7:0]  pc_next_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ins_out;
    logic [7:0]  pc_cur_out;
    logic [7:0]  pc_next_out;
    logic [15:0] stall_cnt;

    logic        in_ready3;
    logic        out_valid3;
    logic [31:0] ins_out3;
    logic [7:0]  pc_cur_out3;
    logic [7:0]  pc_next_out3;
    logic [2:0]  stall_cnt3;

    int checks;
    int failures;

    if_id_pipe #(.INS_W(32), .PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ins_in(ins_in), .pc_cur_in(pc_cur_in), .pc_next_in(pc_next_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ins_out(ins_out), .pc_cur_out(pc_cur_out), .pc_next_out(pc_next_out),
        .stall_cnt(stall_cnt)
    );

    if_id_pipe #(.INS_W(32), .PC_W(8), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3),
        .ins_in(ins_in), .pc_cur_in(pc_cur_in), .pc_next_in(pc_next_in),
        .out_valid(out_valid3), .out_ready(out_ready),
        .ins_out(ins_out3), .pc_cur_out(pc_cur_out3), .pc_next_out(pc_next_out3),
        .stall_cnt(stall_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] ins;
        logic [7:0]  pc;
        logic        ordy;
        logic        fl;
        logic        rs;
        logic        rdy;
        logic        ov;
        logic        chk_pay;
        logic [31:0] e_ins;
        logic [7:0]  e_pc;
        logic [15:0] e_stall;
    } vec_t;

    vec_t tbl [0:14];

    function automatic vec_t mk(input logic vld, input logic [31:0] ins, input logic [7:0] pc,
                                input logic ordy, input logic fl, input logic rs,
                                input logic rdy, input logic ov, input logic chk_pay,
                                input logic [31:0] e_ins, input logic [7:0] e_pc,
                                input logic [15:0] e_stall);
        vec_t v;
        v.vld = vld; v.ins = ins; v.pc = pc; v.ordy = ordy; v.fl = fl; v.rs = rs;
        v.rdy = rdy; v.ov = ov; v.chk_pay = chk_pay;
        v.e_ins = e_ins; v.e_pc = e_pc; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] ins, input logic [7:0] pc,
                       input logic ordy, input logic fl, input logic rs);
        in_valid   = v;
        ins_in     = ins;
        pc_cur_in  = pc;
        pc_next_in = pc + 8'd4;
        out_ready  = ordy;
        flush      = fl;
        rst        = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drv(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    initial begin
        int sent;
        int got;
        logic acc;
        logic [7:0] pcv;
        logic exp_rdy;

        checks   = 0;
        failures = 0;

        tbl[0]  = mk(1, 32'h00500093, 8'h04, 1, 0, 0, 1, 1, 1, 32'h00500093, 8'h04, 16'd0);
        for (int i = 1; i <= 5; i++)
            tbl[i] = mk(0, 32'h0, 8'h0, 0, 0, 0, 0, 1, 1, 32'h00500093, 8'h04, 16'(i));
        tbl[6]  = mk(1, 32'h11111111, 8'h10, 1, 0, 0, 1, 1, 1, 32'h11111111, 8'h10, 16'd5);
        tbl[7]  = mk(0, 32'h0,        8'h00, 1, 0, 0, 1, 0, 0, 32'h0,        8'h00, 16'd5);
        tbl[8]  = mk(1, 32'h22222222, 8'h20, 0, 0, 0, 1, 1, 1, 32'h22222222, 8'h20, 16'd5);
        tbl[9]  = mk(0, 32'h0,        8'h00, 0, 1, 0, 0, 0, 1, 32'h0,        8'h00, 16'd6);
        tbl[10] = mk(1, 32'h33333333, 8'h30, 0, 1, 0, 1, 0, 1, 32'h0,        8'h00, 16'd6);
        tbl[11] = mk(1, 32'h44444444, 8'h40, 1, 0, 0, 1, 1, 1, 32'h44444444, 8'h40, 16'd6);
        tbl[12] = mk(1, 32'h55555555, 8'h50, 0, 0, 1, 0, 0, 1, 32'h0,        8'h00, 16'd0);
        tbl[13] = mk(1, 32'h66666666, 8'h60, 1, 0, 0, 1, 1, 1, 32'h66666666, 8'h60, 16'd0);
        tbl[14] = mk(0, 32'h0,        8'h00, 1, 0, 0, 1, 0, 0, 32'h0,        8'h00, 16'd0);

        // Reset state
        do_reset();
        do_reset();
        drv(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ins_out", ins_out, 0);
        chk("rst_pc_cur", pc_cur_out, 0);
        chk("rst_pc_next", pc_next_out, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_in_ready", in_ready, 1);

        // Vector table
        for (int i = 0; i < 15; i++) begin
            drv(tbl[i].vld, tbl[i].ins, tbl[i].pc, tbl[i].ordy, tbl[i].fl, tbl[i].rs);
            #1;
`ifdef IF_ID_SKID_EN
            exp_rdy = 1'b1;
`else
            exp_rdy = tbl[i].rdy;
`endif
            chk($sformatf("v%0d_in_ready", i), in_ready, exp_rdy);
            tick();
            chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("v%0d_stall", i), stall_cnt, tbl[i].e_stall);
            if (tbl[i].chk_pay) begin
                chk($sformatf("v%0d_ins", i), ins_out, tbl[i].e_ins);
                chk($sformatf("v%0d_pc_cur", i), pc_cur_out, tbl[i].e_pc);
                chk($sformatf("v%0d_pc_next", i), pc_next_out,
                    tbl[i].ov ? 64'(tbl[i].e_pc + 8'd4) : 64'h0);
            end
        end

        // Ten stalled cycles: wide counter reaches 10, 3-bit counter saturates at 7
        do_reset();
        drv(1'b1, 32'hCAFE0001, 8'h80, 1'b0, 1'b0, 1'b0);
        tick();
        drv(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk("stall10_wide", stall_cnt, 10);
        chk("stall10_sat3", stall_cnt3, 7);
        chk("stall10_pc_held", pc_cur_out, 8'h80);
        chk("stall10_ins_held", ins_out, 32'hCAFE0001);
        chk("stall10_c3_valid", out_valid3, 1);
        chk("stall10_c3_ins", ins_out3, 32'hCAFE0001);
        chk("stall10_c3_pc", pc_cur_out3, 8'h80);
        chk("stall10_c3_pcn", pc_next_out3, 8'h84);
`ifdef IF_ID_SKID_EN
        chk("stall10_c3_rdy", in_ready3, 1);
`else
        chk("stall10_c3_rdy", in_ready3, 0);
`endif

        // Stream of 16 entries with out_ready toggling
        do_reset();
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
            pcv = 8'(sent * 4);
            drv(sent < 16, {24'hABCDEF, pcv}, pcv, (cyc % 2) == 0, 1'b0, 1'b0);
            #1;
            if (out_valid && out_ready) begin
                chk("stream_pc", pc_cur_out, 64'(got * 4));
                chk("stream_ins", ins_out, {32'h0, 24'hABCDEF, 8'(got * 4)});
                got++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
        end
        chk("stream_count", got, 16);

        // Flush while held (and skid full when present)
        do_reset();
        drv(1'b1, 32'hA0A0A0A0, 8'h70, 1'b0, 1'b0, 1'b0);
        tick();
        drv(1'b1, 32'hB0B0B0B0, 8'h74, 1'b0, 1'b0, 1'b0);
        tick();
        chk("fl_held_pc", pc_cur_out, 8'h70);
        chk("fl_held_rdy", in_ready, 0);
        drv(1'b1, 32'hC0C0C0C0, 8'h78, 1'b0, 1'b1, 1'b0);
        tick();
        chk("fl_out_valid", out_valid, 0);
        chk("fl_ins_zero", ins_out, 0);
        chk("fl_pc_zero", pc_cur_out, 0);
        drv(1'b1, 32'hD0D0D0D0, 8'h7C, 1'b1, 1'b0, 1'b0);
        tick();
        chk("fl_next_valid", out_valid, 1);
        chk("fl_next_ins", ins_out, 32'hD0D0D0D0);
        chk("fl_next_pc", pc_cur_out, 8'h7C);
        drv(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("fl_drained", out_valid, 0);

`ifdef IF_ID_SKID_EN
        // Skid fill and drain ordering
        do_reset();
        drv(1'b1, 32'h0000000C, 8'h0C, 1'b0, 1'b0, 1'b0);
        tick();
        drv(1'b1, 32'h00000010, 8'h10, 1'b0, 1'b0, 1'b0);
        tick();
        chk("skid_rdy_low", in_ready, 0);
        chk("skid_held_pc", pc_cur_out, 8'h0C);
        drv(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("skid_out_pc", pc_cur_out, 8'h10);
        chk("skid_out_valid", out_valid, 1);
        chk("skid_rdy_back", in_ready, 1);
        tick();
        chk("skid_empty", out_valid, 0);
`endif

        // Reset mid-stall with input pending
        drv(1'b1, 32'h77777777, 8'h90, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drv(1'b1, 32'h88888888, 8'h94, 1'b0, 1'b0, 1'b1);
        tick();
        drv(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_ins", ins_out, 0);
        chk("rst2_pc_next", pc_next_out, 0);
        chk("rst2_stall", stall_cnt, 0);
        chk("rst2_in_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameter INS_W, default 32, instruction word width.
REQ-002 Parameter PC_W, default 8, program-counter width.
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  discard all held and incoming entries (branch/jump redirect).
REQ-007 in_valid  input  1  fetch stage presents an entry.
REQ-008 in_ready  output  1  block accepts the entry this cycle.
REQ-009 ins_in / pc_cur_in / pc_next_in  input  INS_W / PC_W / PC_W  fetched instruction, its PC, PC+4.
REQ-010 out_valid  output  1  decode-side entry present.
REQ-011 out_ready  input  1  decode stage consumes the entry this cycle.
REQ-012 ins_out / pc_cur_out / pc_next_out  output  INS_W / PC_W / PC_W  registered payload.
REQ-013 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-014 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-015 Accepted entries appear at the output one cycle after acceptance when the output register is empty or consumed in the same cycle.
REQ-016 Entries leave in acceptance order, never duplicated, never dropped except by flush or reset.
REQ-017 While out_valid=1 and out_ready=0, out_valid and all payload outputs hold unchanged.
REQ-018 With no input transfer and an output transfer, out_valid clears next cycle.
REQ-019 Simultaneous input and output transfer with no buffered entry loads the new entry into the output register; out_valid stays 1.
REQ-020 flush=1 clears out_valid, clears any buffered entry, and zeroes all payload outputs next cycle; any input accepted that cycle is discarded.
REQ-021 flush has priority over every simultaneous transfer; rst has priority over flush.
REQ-022 stall_cnt increments by 1 each cycle out_valid=1 and out_ready=0, saturates at 2^CNT_W-1, and is unaffected by flush.
REQ-023 All outputs are registered except in_ready when IF_ID_SKID_EN is undefined.

Reset
REQ-024 rst=1 at a clock edge sets out_valid=0, ins_out=0, pc_cur_out=0, pc_next_out=0, stall_cnt=0, and clears any buffered entry.
REQ-025 rst asserted mid-stall or mid-transfer discards all entries; the first acceptance is possible in the cycle after rst deasserts.
REQ-026 in_ready=1 in the first cycle after reset in both configurations.

Configuration
REQ-027 Macro IF_ID_SKID_EN selects the ready scheme.
REQ-028 IF_ID_SKID_EN undefined: no skid storage; in_ready = out_ready || !out_valid, combinational from out_ready.
REQ-029 IF_ID_SKID_EN defined: one skid entry; in_ready = !skid_valid, registered, with no combinational path from out_ready.
REQ-030 Skid mode: an input accepted while the output register is full and not consumed is written into the skid entry.
REQ-031 Skid mode: an output transfer while the skid entry is valid moves the skid entry into the output register and clears skid_valid.
REQ-032 Skid mode sustains one transfer per cycle under continuous in_valid=1 and out_ready=1.

Verification
REQ-033 Reset, then in_valid=1, ins_in=0x00500093, pc_cur_in=0x04, pc_next_in=0x08, out_ready=1 -> next cycle out_valid=1, ins_out=0x00500093, pc_cur_out=0x04, pc_next_out=0x08.
REQ-034 Hold out_ready=0 for 5 cycles with an entry held -> payload unchanged throughout, stall_cnt=5; with CNT_W=3 and 10 stalled cycles -> stall_cnt=7.
REQ-035 Stream entries with PCs 0x00,0x04,...,0x3C at in_valid=1, toggling out_ready 1,0,1,0 -> output PC sequence identical, no gaps or repeats, in both configurations.
REQ-036 flush=1 while the output is held and (skid mode) skid is full, with in_valid=1 -> next cycle out_valid=0 and ins_out=0; the flushed-cycle input never appears; the next accepted entry emerges normally.
REQ-037 Skid mode: out_ready=0 with output full, accept one more entry (PC 0x10) -> in_ready=0 next cycle; out_ready=1 -> held entry leaves, then PC 0x10, then in_ready=1.
REQ-038 rst=1 while in_valid=1 and out_valid=1 -> next cycle out_valid=0, all payload=0, stall_cnt=0, in_ready=1.
